// File: rtl/stl_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the FSM state encoding and the grant-index width derivation.
package stl_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // ceil(log2(n)); REQW is a power of two so this is exact
  function automatic int arb_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stl_rr_pick.sv
// Combinational wrap-around priority pick: first set request at or above ptr,
// searching upward and wrapping from REQW-1 back to 0.
module stl_rr_pick
  import stl_arb_pkg::*;
#(
  parameter int REQW = 16,
  parameter int BINW = arb_clog2(REQW)
) (
  input  logic [REQW-1:0] req_i,
  input  logic [BINW-1:0] ptr_i,
  output logic [REQW-1:0] pick_o,
  output logic [BINW-1:0] idx_o
);

  logic            found;
  logic [BINW-1:0] cand;

  // Index arithmetic wraps naturally because REQW == 2**BINW
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < REQW; i++) begin
      cand = ptr_i + BINW'(i);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/stl_rr_arb.sv
// Round-robin arbiter with a registered, held-until-accepted grant and
// back-to-back grants when requests remain pending at accept.
module stl_rr_arb
  import stl_arb_pkg::*;
#(
  parameter int REQW = 16,
  parameter int BINW = arb_clog2(REQW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REQW-1:0] req_i,
  output logic            gnt_vld_o,
  output logic [REQW-1:0] gnt_oht_o,
  output logic [BINW-1:0] gnt_bin_o,
  input  logic            gnt_rdy_i
);

  arb_state_e      state_q, state_d;
  logic [BINW-1:0] ptr_q, ptr_d;
  logic [REQW-1:0] oht_q, oht_d;
  logic [BINW-1:0] bin_q, bin_d;
  logic [REQW-1:0] pick_oht;
  logic [BINW-1:0] pick_bin;
  logic            any_req;
  logic            accept;

  assign any_req = |req_i;
  assign accept  = (state_q == GRANT) && gnt_rdy_i;
  // The pick for a back-to-back grant must already see the advanced pointer
  assign ptr_d   = accept ? (bin_q + BINW'(1)) : ptr_q;

  stl_rr_pick #(
    .REQW (REQW),
    .BINW (BINW)
  ) u_pick (
    .req_i  (req_i),
    .ptr_i  (ptr_d),
    .pick_o (pick_oht),
    .idx_o  (pick_bin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      oht_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      oht_q   <= oht_d;
      bin_q   <= bin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    oht_d   = oht_q;
    bin_d   = bin_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          oht_d   = pick_oht;
          bin_d   = pick_bin;
        end
      end
      GRANT: begin
        if (accept) begin
          if (any_req) begin
            oht_d = pick_oht;
            bin_d = pick_bin;
          end else begin
            state_d = IDLE;
            oht_d   = '0;
            bin_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        oht_d   = '0;
        bin_d   = '0;
      end
    endcase
  end

  always_comb begin
    gnt_vld_o = (state_q == GRANT);
    gnt_oht_o = oht_q;
    gnt_bin_o = bin_q;
  end

  a_hold_until_accept : assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_vld_o && !gnt_rdy_i) |=> (gnt_vld_o && $stable(gnt_oht_o) && $stable(gnt_bin_o)));

  a_onehot_index : assert property (@(posedge clk) disable iff (!rst_n)
    gnt_vld_o |-> ($onehot(gnt_oht_o) && gnt_oht_o[gnt_bin_o]));

  a_zero_when_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !gnt_vld_o |-> (gnt_oht_o == '0 && gnt_bin_o == '0));

endmodule

// File: tb/tb_stl_rr_arb.sv
// Self-checking bench for stl_rr_arb at REQW=4: vector table plus hand-written
// reset and fairness sequences, expectations flowing through a scoreboard queue.
module tb_stl_rr_arb;

  localparam int REQW = 4;
  localparam int BINW = 2;

  logic            clk;
  logic            rst_n;
  logic [REQW-1:0] req_i;
  logic            gnt_rdy_i;
  logic            gnt_vld_o;
  logic [REQW-1:0] gnt_oht_o;
  logic [BINW-1:0] gnt_bin_o;

  typedef struct {
    logic            vld;
    logic [REQW-1:0] oht;
    logic [BINW-1:0] bin;
  } exp_t;

  typedef struct {
    logic [REQW-1:0] req;
    logic            rdy;
    exp_t            exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  stl_rr_arb #(
    .REQW (REQW),
    .BINW (BINW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .gnt_vld_o (gnt_vld_o),
    .gnt_oht_o (gnt_oht_o),
    .gnt_bin_o (gnt_bin_o),
    .gnt_rdy_i (gnt_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic [REQW-1:0] r, input logic y,
                              input logic v, input logic [REQW-1:0] o,
                              input logic [BINW-1:0] b);
    vec_t t;
    t.req = r; t.rdy = y; t.exp.vld = v; t.exp.oht = o; t.exp.bin = b;
    vecs.push_back(t);
  endfunction

  task automatic push_exp(input logic v, input logic [REQW-1:0] o, input logic [BINW-1:0] b);
    exp_t e;
    e.vld = v; e.oht = o; e.bin = b;
    sb.push_back(e);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got vld=%0b oht=%b bin=%0d", name,
               gnt_vld_o, gnt_oht_o, gnt_bin_o);
    end else begin
      e = sb.pop_front();
      if (gnt_vld_o !== e.vld || gnt_oht_o !== e.oht || gnt_bin_o !== e.bin) begin
        errors++;
        $display("FAIL %s: got vld=%0b oht=%b bin=%0d, required vld=%0b oht=%b bin=%0d",
                 name, gnt_vld_o, gnt_oht_o, gnt_bin_o, e.vld, e.oht, e.bin);
      end else begin
        $display("ok   %s: req=%b rdy=%0b -> vld=%0b oht=%b bin=%0d", name, req_i,
                 gnt_rdy_i, gnt_vld_o, gnt_oht_o, gnt_bin_o);
      end
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, sample just after the edge
  task automatic step(input string name, input logic [REQW-1:0] r, input logic y,
                      input logic v, input logic [REQW-1:0] o, input logic [BINW-1:0] b);
    req_i     = r;
    gnt_rdy_i = y;
    push_exp(v, o, b);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  initial begin
    // idle after reset, ready toggling has no effect
    for (int i = 0; i < 5; i++) add(4'b0000, i[0], 1'b0, 4'b0000, 2'd0);
    // all requesting, always ready: 0,1,2,3,0,1,2,3
    add(4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0);
    add(4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1);
    add(4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2);
    add(4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3);
    add(4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0);
    add(4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1);
    add(4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2);
    add(4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3);
    // accept with nothing pending -> idle, ptr back to 0
    add(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
    // 0110 from ptr 0: grant 1 held, then 2
    add(4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1);
    add(4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1);
    add(4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1);
    add(4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1);
    add(4'b0110, 1'b1, 1'b1, 4'b0100, 2'd2);
    // granted requestor drops its request: grant still held
    add(4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2);
    add(4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2);
    add(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
    // ptr is 3: request 0 only -> wrap to 0; accept leaves ptr at 1
    add(4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0);
    add(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
    add(4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1);
    // back-to-back: other bits win over the just-granted one
    add(4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3);
    add(4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3);
    add(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0);
    add(4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0);
    add(4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2);

    rst_n     = 1'b0;
    req_i     = '0;
    gnt_rdy_i = 1'b0;
    #2;
    push_exp(1'b0, 4'b0000, 2'd0);
    check_out("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].rdy,
           vecs[i].exp.vld, vecs[i].exp.oht, vecs[i].exp.bin);

    // asynchronous reset while granting index 2
    rst_n = 1'b0;
    #1;
    push_exp(1'b0, 4'b0000, 2'd0);
    check_out("async_reset_mid_grant");
    @(posedge clk);
    #1;
    push_exp(1'b0, 4'b0000, 2'd0);
    check_out("reset_held");
    rst_n = 1'b1;
    step("post_reset_first", 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0);
    step("post_reset_second", 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1);

    // fairness: continuous full request, expected rotation 2,3,0,1,...
    for (int k = 0; k < 12; k++) begin
      logic [BINW-1:0] b;
      logic [REQW-1:0] o;
      b = BINW'(2 + k);
      o = '0;
      o[b] = 1'b1;
      step($sformatf("fair%0d", k), 4'b1111, 1'b1, 1'b1, o, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stl_rr_arb.md
STL_RR_ARB -- requirements
Module: stl_rr_arb

Interface
REQ-001 Parameter REQW, default 16, SHALL set the number of requestors; it is a power of two and at least 2.
REQ-002 Parameter BINW, default 4, SHALL equal log2(REQW) and sets the binary grant index width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 req_i  input  REQW  SHALL carry per-requestor request levels; bit k high means requestor k wants a grant.
REQ-006 gnt_vld_o  output  1  SHALL indicate a grant is presented.
REQ-007 gnt_oht_o  output  REQW  SHALL be the one-hot grant vector, all-zero when gnt_vld_o is low.
REQ-008 gnt_bin_o  output  BINW  SHALL be the binary index of the set bit of gnt_oht_o, zero when gnt_vld_o is low.
REQ-009 gnt_rdy_i  input  1  SHALL be the downstream ready; a grant is accepted in a cycle where gnt_vld_o and gnt_rdy_i are both high.

Function
REQ-010 FSM SHALL have two states: IDLE (no grant held) and GRANT (grant registered, awaiting accept).
REQ-011 IDLE -> GRANT SHALL occur on the first edge where |req_i is high; the chosen grant is registered, so latency is 1 cycle from request to gnt_vld_o.
REQ-012 The chosen requestor SHALL be the first set bit of req_i at or above index ptr, searching upward with wrap from REQW-1 to 0.
REQ-013 ptr SHALL be a BINW-bit register, reset to 0, updated only on accept to (granted index + 1) mod REQW.
REQ-014 In GRANT, gnt_oht_o, gnt_bin_o and gnt_vld_o SHALL hold stable until accept, regardless of req_i changes, including the granted requestor deasserting.
REQ-015 On accept with |req_i high, the FSM SHALL stay in GRANT and register the next grant using the updated ptr; gnt_vld_o stays high, giving back-to-back grants with no bubble.
REQ-016 On accept with req_i all-zero, the FSM SHALL go to IDLE and drive gnt_vld_o low the next cycle.
REQ-017 The arbitration for a back-to-back grant SHALL use req_i sampled in the accept cycle; the just-granted requestor is eligible only if no other bit is set.
REQ-018 gnt_oht_o SHALL be exactly one-hot whenever gnt_vld_o is high, and gnt_bin_o SHALL equal its index.
REQ-019 Fairness: with all REQW requests continuously high and gnt_rdy_i tied high, each requestor SHALL be granted exactly once in every REQW consecutive grants.
REQ-020 gnt_rdy_i high while gnt_vld_o is low SHALL have no effect.

Reset
REQ-021 On rst_n low, the block SHALL asynchronously enter IDLE with ptr=0, gnt_vld_o=0, gnt_oht_o=0 and gnt_bin_o=0.
REQ-022 Reset asserted mid-GRANT SHALL discard the pending grant without an accept; after release, arbitration restarts from ptr=0.
REQ-023 The first grant SHALL be evaluated at the first rising edge after rst_n deasserts.

Structure
REQ-024 A shared package stl_arb_pkg SHALL hold the FSM state enum typedef (IDLE, GRANT) and the helper for the BINW width derivation.
REQ-025 The wrap-around masked priority pick SHALL be a combinational sub-module stl_rr_pick, with inputs req and ptr and output one-hot pick plus binary index.
REQ-026 Assertions SHALL check REQ-014, REQ-018 and that gnt_oht_o is zero when gnt_vld_o is low, disabled while rst_n is low.

Verification (REQW=4)
REQ-027 Reset release, req_i=4'b0000 for 5 cycles -> gnt_vld_o stays 0 and all outputs stay 0.
REQ-028 req_i=4'b1111, gnt_rdy_i=1 continuously -> gnt_bin_o sequence 0,1,2,3,0,... with gnt_vld_o high every cycle from the 2nd cycle on.
REQ-029 req_i=4'b0110, ptr=0, gnt_rdy_i=0 for 3 cycles, then 1 -> gnt_oht_o=4'b0010 held 4 cycles, then 4'b0100 next.
REQ-030 Granted requestor 2 drops req_i to 0 while gnt_rdy_i=0 -> grant 4'b0100 held; accept -> next cycle gnt_vld_o=0.
REQ-031 ptr=3 with req_i=4'b0001 -> wrap, gnt_bin_o=0; after accept ptr=1.
REQ-032 rst_n pulsed low during GRANT with gnt_bin_o=2 -> outputs 0 immediately; with req_i=4'b1111 after release, the first grant is index 0.
